// File: rtl/pixel_mem_arbiter_if.sv
// Pixel memory arbiter bus: host and calc requesters plus the RAM port.
// master drives requests and mem_q; slave is the arbiter.
interface pixel_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              calc_req;
  logic [ADDR_W-1:0] calc_addr;
  logic              calc_gnt;
  logic              calc_rvalid;
  logic [DATA_W-1:0] calc_rdata;
  logic              calc_lock;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  calc_req, calc_addr, calc_lock, mem_q,
    output host_gnt, host_rvalid, host_rdata,
    output calc_gnt, calc_rvalid, calc_rdata,
    output mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output calc_req, calc_addr, calc_lock, mem_q,
    input  host_gnt, host_rvalid, host_rdata,
    input  calc_gnt, calc_rvalid, calc_rdata,
    input  mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/pixel_mem_arbiter.sv
// Round-robin host/calc arbiter for the single-port pixel RAM.
// Optional PIXEL_ARB_CONFLICT_CNT_EN adds a saturating contention counter.
module pixel_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic n_rst,
  pixel_mem_arbiter_if.slave bus
`ifdef PIXEL_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CALC = 1'b1
  } owner_e;

  owner_e            last_q, last_d;
  logic              host_elig, calc_elig;
  logic              host_win, calc_win;
  logic              push;
  logic [RD_LAT-1:0] vld_q, own_q;
  logic [DATA_W-1:0] hrd_q, crd_q;

  always_comb begin
    host_elig = bus.host_req & ~(bus.host_we & bus.calc_lock);
    calc_elig = bus.calc_req;
    host_win  = 1'b0;
    calc_win  = 1'b0;
    last_d    = last_q;
    if (host_elig && calc_elig) begin
      if (last_q == OWN_HOST) calc_win = 1'b1;
      else                    host_win = 1'b1;
    end else begin
      host_win = host_elig;
      calc_win = calc_elig;
    end
    // no access may reach the RAM while reset is held
    host_win = host_win & n_rst;
    calc_win = calc_win & n_rst;
    if (host_win)      last_d = OWN_HOST;
    else if (calc_win) last_d = OWN_CALC;
  end

  assign push          = (host_win & ~bus.host_we) | calc_win;
  assign bus.host_gnt  = host_win;
  assign bus.calc_gnt  = calc_win;
  assign bus.mem_wren  = host_win & bus.host_we;
  assign bus.mem_wdata = bus.host_wdata;
  assign bus.mem_addr  = host_win ? bus.host_addr :
                         calc_win ? bus.calc_addr : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q <= OWN_HOST;
      vld_q  <= '0;
      own_q  <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= (vld_q << 1) | RD_LAT'(push);
      own_q  <= (own_q << 1) | RD_LAT'(calc_win);
    end
  end

  assign bus.host_rvalid = vld_q[RD_LAT-1] & ~own_q[RD_LAT-1];
  assign bus.calc_rvalid = vld_q[RD_LAT-1] &  own_q[RD_LAT-1];
  assign bus.host_rdata  = bus.host_rvalid ? bus.mem_q : hrd_q;
  assign bus.calc_rdata  = bus.calc_rvalid ? bus.mem_q : crd_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hrd_q <= '0;
      crd_q <= '0;
    end else begin
      if (bus.host_rvalid) hrd_q <= bus.mem_q;
      if (bus.calc_rvalid) crd_q <= bus.mem_q;
    end
  end

`ifdef PIXEL_ARB_CONFLICT_CNT_EN
  logic        lock_q;
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lock_q <= bus.calc_lock;
      if (bus.calc_lock && !lock_q)
        cnt_q <= '0;
      else if (host_elig && calc_elig && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  // counter absent; arbitration above is unchanged
`endif

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Bench for pixel_mem_arbiter: RAM model, transaction-level checker,
// and directed scenarios with literal expectations.
module tb_pixel_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  logic clk;
  logic n_rst;
  bit   go;
  int   total;
  int   bad;
  int   cyc;

  pixel_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef PIXEL_ARB_CONFLICT_CNT_EN
  logic [15:0] cc;
  pixel_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .conflict_cnt(cc)
  );
`else
  pixel_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] seed(input int a);
    return 16'h1000 + 16'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM with RD_LAT-deep registered read path
  logic [15:0] ram [0:1023];
  logic [15:0] qp [RD_LAT];
  bit          ram_init;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= seed(i);
      ram_init <= 1'b1;
    end else if (bus.mem_wren) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    qp[0] <= ram[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign bus.mem_q = qp[RD_LAT-1];

  // Transaction model: expected owner, returns queued with due cycle
  typedef struct {
    int          due;
    bit          calc;
    logic [15:0] d;
  } rd_t;
  rd_t         rq[$];
  rd_t         e;
  logic [15:0] mmem [0:1023];
  bit          m_init;
  bit          m_last_calc;
  logic [15:0] ehrd, ecrd;
  bit          ehv, ecv, he, ce, wh, wc;

  always @(negedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 1024; i++) mmem[i] = seed(i);
      m_init = 1'b1;
    end
    if (go && !n_rst) begin
      chk("m_rst_hg", bus.host_gnt, 0);
      chk("m_rst_cg", bus.calc_gnt, 0);
      chk("m_rst_hv", bus.host_rvalid, 0);
      chk("m_rst_cv", bus.calc_rvalid, 0);
      chk("m_rst_wr", bus.mem_wren, 0);
      chk("m_rst_hd", bus.host_rdata, 0);
      chk("m_rst_cd", bus.calc_rdata, 0);
      rq.delete();
      m_last_calc = 1'b0;
      ehrd = '0;
      ecrd = '0;
    end else if (go) begin
      ehv = 1'b0;
      ecv = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        if (e.calc) begin ecv = 1'b1; ecrd = e.d; end
        else        begin ehv = 1'b1; ehrd = e.d; end
      end
      chk("m_hv", bus.host_rvalid, ehv);
      chk("m_cv", bus.calc_rvalid, ecv);
      chk("m_hd", bus.host_rdata, ehrd);
      chk("m_cd", bus.calc_rdata, ecrd);
      he = bus.host_req && !(bus.host_we && bus.calc_lock);
      ce = bus.calc_req;
      wh = he && (!ce || m_last_calc);
      wc = ce && (!he || !m_last_calc);
      chk("m_hg", bus.host_gnt, wh);
      chk("m_cg", bus.calc_gnt, wc);
      chk("m_wr", bus.mem_wren, wh && bus.host_we);
      if (wh) begin
        chk("m_ah", bus.mem_addr, bus.host_addr);
        m_last_calc = 1'b0;
        if (bus.host_we) begin
          chk("m_wd", bus.mem_wdata, bus.host_wdata);
          mmem[bus.host_addr] = bus.host_wdata;
        end else begin
          rq.push_back('{cyc + RD_LAT, 1'b0, mmem[bus.host_addr]});
        end
      end else if (wc) begin
        chk("m_ac", bus.mem_addr, bus.calc_addr);
        m_last_calc = 1'b1;
        rq.push_back('{cyc + RD_LAT, 1'b1, mmem[bus.calc_addr]});
      end else begin
        chk("m_a0", bus.mem_addr, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rvs;

  initial begin
    total = 0; bad = 0; cyc = 0;
    n_rst = 1'b1;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.calc_req = 0; bus.calc_addr = '0;
    bus.calc_lock = 0;
    #2 n_rst = 1'b0;
    go = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_hd", bus.host_rdata, 0);
    chk("rst_hv", bus.host_rvalid, 0);
`ifdef PIXEL_ARB_CONFLICT_CNT_EN
    chk("rst_cc", cc, 0);
`endif
    tick();
    n_rst = 1'b1;

    // write 5 = BEEF then read it back
    bus.host_req = 1; bus.host_we = 1;
    bus.host_addr = 10'd5; bus.host_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t1_wgnt", bus.host_gnt, 1);
    chk("t1_wren", bus.mem_wren, 1);
    tick();
    bus.host_we = 0;
    @(negedge clk);
    chk("t1_rgnt", bus.host_gnt, 1);
    tick();
    bus.host_req = 0;
    repeat (RD_LAT - 1) tick();
    @(negedge clk);
    chk("t1_rv", bus.host_rvalid, 1);
    chk("t1_rd", bus.host_rdata, 16'hBEEF);
    tick();

    // contention: calc wins first tie after a host grant
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 10'd7;
    bus.calc_req = 1; bus.calc_addr = 10'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_cg", bus.calc_gnt, (i % 2) == 0);
      chk("t2_hg", bus.host_gnt, (i % 2) == 1);
      tick();
    end
    bus.host_req = 0; bus.calc_req = 0;
    repeat (RD_LAT + 1) tick();

    // host write then calc read of the same address
    bus.host_req = 1; bus.host_we = 1;
    bus.host_addr = 10'd20; bus.host_wdata = 16'hA5A5;
    @(negedge clk);
    chk("b_wgnt", bus.host_gnt, 1);
    tick();
    bus.host_req = 0; bus.host_we = 0;
    bus.calc_req = 1; bus.calc_addr = 10'd20;
    @(negedge clk);
    chk("b_cgnt", bus.calc_gnt, 1);
    tick();
    bus.calc_req = 0;
    repeat (RD_LAT - 1) tick();
    @(negedge clk);
    chk("b_cv", bus.calc_rvalid, 1);
    chk("b_cd", bus.calc_rdata, 16'hA5A5);
    tick();

    // lock stalls a pending host write
    bus.calc_lock = 1;
    bus.host_req = 1; bus.host_we = 1;
    bus.host_addr = 10'd9; bus.host_wdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_gnt0", bus.host_gnt, 0);
      chk("t3_wr0", bus.mem_wren, 0);
      tick();
    end
    bus.calc_lock = 0;
    @(negedge clk);
    chk("t3_gnt1", bus.host_gnt, 1);
    chk("t3_wr1", bus.mem_wren, 1);
    tick();
    bus.host_req = 0; bus.host_we = 0;

    // calc stream 0..9 with no bubbles
    for (int k = 0; k < 10 + RD_LAT + 2; k++) begin
      bus.calc_req = (k < 10);
      bus.calc_addr = (k < 10) ? 10'(k) : '0;
      @(negedge clk);
      if (k < 10) chk("t4_gnt", bus.calc_gnt, 1);
      chk("t4_rv", bus.calc_rvalid, (k >= RD_LAT) && (k < 10 + RD_LAT));
      if (k == RD_LAT)     chk("t4_d0", bus.calc_rdata, 16'h1000);
      if (k == RD_LAT + 5) chk("t4_d5", bus.calc_rdata, 16'hBEEF);
      if (k == RD_LAT + 9) chk("t4_d9", bus.calc_rdata, 16'h1234);
      tick();
    end

    // reset one cycle after a read grant drops the read
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 10'd5;
    @(negedge clk);
    chk("t5_gnt", bus.host_gnt, 1);
    tick();
    n_rst = 1'b0;
    @(negedge clk);
    chk("t5_hg", bus.host_gnt, 0);
    chk("t5_hv", bus.host_rvalid, 0);
    chk("t5_ad", bus.mem_addr, 0);
    chk("t5_hd", bus.host_rdata, 0);
    chk("t5_cd", bus.calc_rdata, 0);
    tick();
    bus.host_req = 0;
    n_rst = 1'b1;
    rvs = 0;
    repeat (RD_LAT + 3) begin
      @(negedge clk);
      rvs += int'(bus.host_rvalid) + int'(bus.calc_rvalid);
      tick();
    end
    chk("t5_norv", rvs, 0);

`ifdef PIXEL_ARB_CONFLICT_CNT_EN
    bus.host_req = 1; bus.host_addr = 10'd1;
    bus.calc_req = 1; bus.calc_addr = 10'd2;
    repeat (7) tick();
    bus.host_req = 0; bus.calc_req = 0;
    @(negedge clk);
    chk("t6_cnt7", cc, 7);
    tick();
    bus.calc_lock = 1;
    tick();
    @(negedge clk);
    chk("t6_clr", cc, 0);
    bus.host_req = 1; bus.calc_req = 1;
    tick();
    repeat (65540) tick();
    bus.host_req = 0; bus.calc_req = 0;
    @(negedge clk);
    chk("t6_sat", cc, 16'hFFFF);
    tick();
    @(negedge clk);
    chk("t6_hold", cc, 16'hFFFF);
    bus.calc_lock = 0;
    tick();
`endif

    repeat (RD_LAT + 2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
